// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the PDM microphone front end.
package audio_pkg;

    localparam int unsigned CIC_ORDER = 3;
    localparam int unsigned AUDIO_W   = 12;
    localparam logic [AUDIO_W-1:0] AUDIO_MIDSCALE = 12'h800;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } mic_state_e;

endpackage

// File: rtl/cic_decim3.sv
// Third-order CIC decimator: integrators at the PDM tick rate, a wrap counter
// that marks decimation events, a three-stage comb pipeline and saturation.
module cic_decim3
    import audio_pkg::*;
#(
    parameter int unsigned DECIM_LOG2 = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               bit_i,
    input  logic               tick_i,
    output logic               dec_stb_o,
    output logic [AUDIO_W-1:0] result_c_o
);

    localparam int unsigned W = CIC_ORDER * DECIM_LOG2 + 1;

    logic [W-1:0]            int_q  [CIC_ORDER];
    logic [W-1:0]            int_d  [CIC_ORDER];
    logic [W-1:0]            comb_q [CIC_ORDER];
    logic [W-1:0]            comb_d [CIC_ORDER];
    logic [W-1:0]            dly_q  [CIC_ORDER];
    logic [W-1:0]            dly_d  [CIC_ORDER];
    logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
    logic [CIC_ORDER:0]      vld_q, vld_d;
    logic                    unused_lsbs;

    // Integrate on ticks; walk a decimation event down the comb stages one per cycle.
    always_comb begin
        int_d  = int_q;
        cnt_d  = cnt_q;
        comb_d = comb_q;
        dly_d  = dly_q;
        vld_d  = {vld_q[CIC_ORDER-1:0], tick_i && (cnt_q == '1)};
        if (tick_i) begin
            int_d[0] = int_q[0] + W'(bit_i);
            for (int s = 1; s < CIC_ORDER; s++) begin
                int_d[s] = int_q[s] + int_q[s-1];
            end
            cnt_d = cnt_q + DECIM_LOG2'(1);
        end
        if (vld_q[0]) begin
            comb_d[0] = int_q[CIC_ORDER-1] - dly_q[0];
            dly_d[0]  = int_q[CIC_ORDER-1];
        end
        for (int s = 1; s < CIC_ORDER; s++) begin
            if (vld_q[s]) begin
                comb_d[s] = comb_q[s-1] - dly_q[s];
                dly_d[s]  = comb_q[s-1];
            end
        end
    end

    // Filter state; a clear drops any event still in the comb pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int s = 0; s < CIC_ORDER; s++) begin
                int_q[s]  <= '0;
                comb_q[s] <= '0;
                dly_q[s]  <= '0;
            end
            cnt_q <= '0;
            vld_q <= '0;
        end else begin
            int_q  <= int_d;
            comb_q <= comb_d;
            dly_q  <= dly_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    // Full scale (R^3) lands on the MSB; clamp it to the largest positive value.
    assign dec_stb_o   = vld_q[CIC_ORDER];
    assign result_c_o  = comb_q[CIC_ORDER-1][W-1] ? '1 : comb_q[CIC_ORDER-1][W-2 -: AUDIO_W];
    assign unused_lsbs = ^comb_q[CIC_ORDER-1];

endmodule

// File: rtl/pdm_mic_decimator.sv
// PDM microphone front end: input synchronizer, PDM clock divider, run/idle
// FSM and the registered 12-bit audio output.
module pdm_mic_decimator
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 6,
    parameter int unsigned DECIM_LOG2 = 6
) (
    input  logic               wb_clk_i,
    input  logic               wb_reset_i,
    input  logic               enable_i,
    input  logic               pdm_dat_i,
    output logic               pdm_clk_o,
    output logic [AUDIO_W-1:0] audio_o,
    output logic               sample_stb_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    mic_state_e         state_q, state_d;
    logic [1:0]         sync_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               pdm_clk_q, pdm_clk_d;
    logic [1:0]         warm_q, warm_d;
    logic [AUDIO_W-1:0] audio_q, audio_d;
    logic               stb_q, stb_d;
    logic               tick_c;
    logic               clear_c;
    logic               dec_stb;
    logic [AUDIO_W-1:0] cic_result;

    cic_decim3 #(
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_cic (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_reset_i),
        .clear_i    (clear_c),
        .bit_i      (sync_q[1]),
        .tick_i     (tick_c),
        .dec_stb_o  (dec_stb),
        .result_c_o (cic_result)
    );

    // Two-flop synchronizer for the asynchronous PDM data.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pdm_dat_i};
        end
    end

    // Next state: divider/tick generation, warm-up event count, output update.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pdm_clk_d = pdm_clk_q;
        warm_d    = warm_q;
        audio_d   = audio_q;
        stb_d     = 1'b0;
        tick_c    = 1'b0;
        clear_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                div_d     = '0;
                pdm_clk_d = 1'b0;
                warm_d    = '0;
                audio_d   = AUDIO_MIDSCALE;
                clear_c   = 1'b1;
                if (enable_i) begin
                    state_d = ST_WARMUP;
                end
            end
            ST_WARMUP, ST_RUN: begin
                if (!enable_i) begin
                    state_d   = ST_IDLE;
                    div_d     = '0;
                    pdm_clk_d = 1'b0;
                    warm_d    = '0;
                    audio_d   = AUDIO_MIDSCALE;
                    clear_c   = 1'b1;
                end else begin
                    if (div_q == DIV_LAST) begin
                        div_d     = '0;
                        pdm_clk_d = !pdm_clk_q;
                        tick_c    = pdm_clk_q;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                    if (dec_stb) begin
                        if (state_q == ST_RUN) begin
                            audio_d = cic_result;
                            stb_d   = 1'b1;
                        end else if (warm_q == 2'd2) begin
                            state_d = ST_RUN;
                        end else begin
                            warm_d = warm_q + 2'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            pdm_clk_q <= 1'b0;
            warm_q    <= '0;
            audio_q   <= AUDIO_MIDSCALE;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pdm_clk_q <= pdm_clk_d;
            warm_q    <= warm_d;
            audio_q   <= audio_d;
            stb_q     <= stb_d;
        end
    end

    assign pdm_clk_o    = pdm_clk_q;
    assign audio_o      = audio_q;
    assign sample_stb_o = stb_q;

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Bench for pdm_mic_decimator: FIR-form CIC reference model checked every cycle.
module tb_pdm_mic_decimator;

    localparam int CLK_DIV    = 6;
    localparam int DECIM_LOG2 = 6;
    localparam int R          = 1 << DECIM_LOG2;
    localparam int W          = 3 * DECIM_LOG2 + 1;
    localparam int PER        = 2 * CLK_DIV;
    localparam int NTAP       = 3 * R - 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        dat;
    logic        pclk;
    logic [11:0] audio;
    logic        stb;

    always #5 clk = ~clk;

    pdm_mic_decimator #(
        .CLK_DIV    (CLK_DIV),
        .DECIM_LOG2 (DECIM_LOG2)
    ) dut (
        .wb_clk_i     (clk),
        .wb_reset_i   (rst),
        .enable_i     (en),
        .pdm_dat_i    (dat),
        .pdm_clk_o    (pclk),
        .audio_o      (audio),
        .sample_stb_o (stb)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state
    int          h [NTAP];
    bit          xs [$];
    bit          m_act = 1'b0;
    int          age   = 0;
    bit          d1 = 1'b0, d2 = 1'b0;
    bit          pend = 1'b0;
    int          pend_age = 0;
    logic [11:0] pend_val;
    logic        exp_clk   = 1'b0;
    logic        exp_stb   = 1'b0;
    logic [11:0] exp_audio = 12'h800;
    int          kev;

    // Stimulus / literal-check controls
    int          mode    = 0;
    bit          lit_on  = 1'b0;
    logic [11:0] lit_val = 12'h000;
    int          last_rise = -1;
    int          last_stb_age = -1;
    logic        prev_pclk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Decimated CIC output as a direct FIR: boxcar^3 kernel, two-tick integrator delay.
    function automatic logic [11:0] model_sample(input int n);
        longint acc = 0;
        for (int j = 0; j < NTAP; j++) begin
            if (n - 2 - j >= 0) acc += longint'(h[j]) * longint'(xs[n-2-j]);
        end
        if (acc >= (longint'(1) << (W - 1))) acc = (longint'(1) << (W - 1)) - 1;
        return 12'(acc >> (W - 13));
    endfunction

    // Model advance at each clock edge from the inputs seen during the previous cycle.
    always @(posedge clk) begin
        cyc++;
        d2 = d1;
        d1 = dat;
        exp_stb = 1'b0;
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (en) begin
                m_act = 1'b1;
                age   = 0;
                xs.delete();
                pend  = 1'b0;
            end
        end else if (!en) begin
            m_act = 1'b0;
        end else begin
            age++;
        end
        if (!m_act) begin
            exp_clk   = 1'b0;
            exp_audio = 12'h800;
            pend      = 1'b0;
        end else begin
            exp_clk = ((age / CLK_DIV) % 2) == 1;
            if (pend && age == pend_age) begin
                exp_stb   = 1'b1;
                exp_audio = pend_val;
                pend      = 1'b0;
            end
            if (age % PER == PER - 1) begin
                xs.push_back(d2);
                if (xs.size() % R == 0) begin
                    kev = xs.size() / R;
                    if (kev >= 4) begin
                        pend     = 1'b1;
                        pend_age = age + 5;
                        pend_val = model_sample(xs.size() - 1);
                    end
                end
            end
        end
    end

    // Per-cycle compare, literal timing pins, then drive the next data bit.
    always @(negedge clk) begin
        check("pdm_clk", 32'(pclk), 32'(exp_clk));
        check("sample_stb", 32'(stb), 32'(exp_stb));
        check("audio", 32'(audio), 32'(exp_audio));
        if (stb && m_act) begin
            if (lit_on) check("audio_literal", 32'(audio), 32'(lit_val));
            if (last_stb_age >= 0) check("stb_spacing", 32'(age - last_stb_age), 32'd768);
            else                   check("first_stb_age", 32'(age), 32'd3076);
            last_stb_age = age;
        end
        if (pclk && !prev_pclk && m_act) begin
            if (last_rise >= 0) check("pdm_period", 32'(cyc - last_rise), 32'd12);
            else                check("first_rise_age", 32'(age), 32'd6);
            last_rise = cyc;
        end
        if (!m_act) begin
            last_rise    = -1;
            last_stb_age = -1;
        end
        prev_pclk = pclk;
        case (mode)
            0:       dat = 1'b0;
            1:       dat = 1'b1;
            2:       dat = 1'(((age + 3) / PER) % 2);
            default: dat = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        int w;
        for (int j = 0; j < NTAP; j++) h[j] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a+b+c]++;

        rst = 1'b1; en = 1'b0; dat = 1'b0;
        run(3);
        check("reset_pdm_clk", 32'(pclk), 32'd0);
        check("reset_audio", 32'(audio), 32'h800);
        check("reset_stb", 32'(stb), 32'd0);

        // Silence: mic held low
        rst = 1'b0; mode = 0; lit_on = 1'b1; lit_val = 12'h000; en = 1'b1;
        run(3076 + 3 * 768 + 20);
        en = 1'b0; run(5);

        // Full scale: mic held high, saturates
        mode = 1; lit_val = 12'hFFF; en = 1'b1;
        run(3076 + 2 * 768 + 100);

        // One-cycle reset mid-RUN, enable still high
        rst = 1'b1; run(1); rst = 1'b0;
        check("midrun_reset_pdm_clk", 32'(pclk), 32'd0);
        check("midrun_reset_audio", 32'(audio), 32'h800);
        check("midrun_reset_stb", 32'(stb), 32'd0);
        run(3076 + 2 * 768 + 100);
        en = 1'b0; run(5);

        // Alternating bits: midscale
        mode = 2; lit_val = 12'h800; en = 1'b1;
        run(3076 + 2 * 768 + 100);

        // Drop enable while a sample is still in the comb pipeline
        w = 0;
        while (!(pend && age == pend_age - 3) && w < 2000) begin
            run(1);
            w++;
        end
        check("inflight_wait", 32'(w < 2000), 32'd1);
        en = 1'b0;
        run(1);
        check("drop_pdm_clk", 32'(pclk), 32'd0);
        check("drop_audio", 32'(audio), 32'h800);
        check("drop_stb", 32'(stb), 32'd0);
        run(10);

        // Random data, full warm-up again after re-enable
        mode = 3; lit_on = 1'b0; en = 1'b1;
        run(3076 + 3 * 768);

        // Random enable sessions, one with a reset pulse
        for (int i = 0; i < 6; i++) begin
            en = 1'b1;
            run(int'($urandom_range(200, 4500)));
            if (i == 3) begin
                rst = 1'b1; run(1); rst = 1'b0;
                run(int'($urandom_range(3200, 4000)));
            end
            en = 1'b0;
            run(int'($urandom_range(1, 15)));
        end
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
